// File: rtl/vmicro16_apb_master_bridge_if.sv
// Core-side request/ack and APB master signals of one bridge instance.
// The bridge uses the master modport; the environment (core + APB slave) uses slave.
interface vmicro16_apb_master_bridge_if #(
    parameter int BUS_WIDTH  = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  C_REQ;
    logic                  C_WE;
    logic [BUS_WIDTH-1:0]  C_ADDR;
    logic [DATA_WIDTH-1:0] C_WDATA;
    logic                  C_ACK;
    logic [DATA_WIDTH-1:0] C_RDATA;
    logic                  C_ERR;

    logic [BUS_WIDTH-1:0]  M_PADDR;
    logic                  M_PWRITE;
    logic                  M_PSELx;
    logic                  M_PENABLE;
    logic [DATA_WIDTH-1:0] M_PWDATA;
    logic [DATA_WIDTH-1:0] M_PRDATA;
    logic                  M_PREADY;

    modport master (
        input  C_REQ, C_WE, C_ADDR, C_WDATA,
        output C_ACK, C_RDATA, C_ERR,
        output M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA,
        input  M_PRDATA, M_PREADY
    );

    modport slave (
        output C_REQ, C_WE, C_ADDR, C_WDATA,
        input  C_ACK, C_RDATA, C_ERR,
        input  M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA,
        output M_PRDATA, M_PREADY
    );
endinterface

// File: rtl/vmicro16_apb_master_bridge.sv
// Core load/store to APB3 master bridge with a posted-write buffer; loads drain the buffer first.
// Optional ACCESS-phase timeout: define VMICRO16_APB_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | no transfer; pick buffered write first, else a pending load
//   SETUP  | PSEL=1, PENABLE=0, address/direction/data presented for one cycle
//   ACCESS | PENABLE=1, wait for PREADY (or timeout when enabled)
module vmicro16_apb_master_bridge #(
    parameter int BUS_WIDTH      = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int WBUF_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    vmicro16_apb_master_bridge_if.master bus
);
    localparam int AW = $clog2(WBUF_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state_q, state_d;
    logic [BUS_WIDTH-1:0]  wb_addr_q [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] wb_data_q [WBUF_DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [BUS_WIDTH-1:0]  paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  c_ack_q, c_ack_d;
    logic                  c_err_q, c_err_d;
    logic [DATA_WIDTH-1:0] c_rdata_q, c_rdata_d;
    logic                  fifo_full, fifo_empty, push, load_go, tmo_hit;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // The request is still held during its own ack cycle, so nothing is accepted then.
    assign push    = bus.C_REQ && bus.C_WE && !fifo_full && !c_ack_q;
    assign load_go = bus.C_REQ && !bus.C_WE && fifo_empty && !c_ack_q;

`ifdef VMICRO16_APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end

    // Down-counter armed in SETUP; reaching zero in ACCESS marks the last allowed cycle.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == SETUP)
            tmo_d = TW'(TIMEOUT_CYCLES - 1);
        else if (state_q == ACCESS && tmo_q != '0)
            tmo_d = tmo_q - 1'b1;
    end

    assign tmo_hit = (state_q == ACCESS) && (tmo_q == '0);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign tmo_hit        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr_q[wptr_q[AW-1:0]] <= bus.C_ADDR;
            wb_data_q[wptr_q[AW-1:0]] <= bus.C_WDATA;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            c_ack_q   <= 1'b0;
            c_err_q   <= 1'b0;
            c_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            c_ack_q   <= c_ack_d;
            c_err_q   <= c_err_d;
            c_rdata_q <= c_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        c_ack_d   = 1'b0;
        c_err_d   = 1'b0;
        c_rdata_d = c_rdata_q;

        if (push) begin
            wptr_d  = wptr_q + 1'b1;
            c_ack_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d   = SETUP;
                    paddr_d   = wb_addr_q[rptr_q[AW-1:0]];
                    pwdata_d  = wb_data_q[rptr_q[AW-1:0]];
                    pwrite_d  = 1'b1;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end else if (load_go) begin
                    state_d   = SETUP;
                    paddr_d   = bus.C_ADDR;
                    pwrite_d  = 1'b0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (bus.M_PREADY || tmo_hit) begin
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (pwrite_q) begin
                        rptr_d = rptr_q + 1'b1;
                    end else begin
                        c_ack_d   = 1'b1;
                        c_err_d   = !bus.M_PREADY;
                        c_rdata_d = bus.M_PREADY ? bus.M_PRDATA : DATA_WIDTH'(16'hDEAD);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    assign bus.C_ACK     = c_ack_q;
    assign bus.C_ERR     = c_err_q;
    assign bus.C_RDATA   = c_rdata_q;
    assign bus.M_PADDR   = paddr_q;
    assign bus.M_PWRITE  = pwrite_q;
    assign bus.M_PSELx   = psel_q;
    assign bus.M_PENABLE = penable_q;
    assign bus.M_PWDATA  = pwdata_q;
endmodule

// File: tb/tb_vmicro16_apb_master_bridge.sv
// Bench for the APB master bridge: directed scenarios plus a random load/store mix
// checked against a program-order memory model and an expected APB transfer list.
module tb_vmicro16_apb_master_bridge;
    localparam int BW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vmicro16_apb_master_bridge_if #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) bus ();

    vmicro16_apb_master_bridge #(
        .BUS_WIDTH(BW), .DATA_WIDTH(DW), .WBUF_DEPTH(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    // Environment: APB slave memory, wait-state count, and completed-transfer log.
    logic [15:0] slave_mem [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];
    logic [32:0] apb_log [$];
    logic [32:0] exp_log [$];
    int slave_wait = 0;
    int wait_cnt = 0;

    always @(negedge clk) begin
        if (bus.M_PSELx && bus.M_PENABLE) begin
            if (wait_cnt >= slave_wait) begin
                bus.M_PREADY = 1'b1;
                bus.M_PRDATA = slave_mem.exists(bus.M_PADDR) ? slave_mem[bus.M_PADDR]
                                                             : (bus.M_PADDR ^ 16'hA5A5);
            end else begin
                bus.M_PREADY = 1'b0;
                wait_cnt++;
            end
        end else begin
            bus.M_PREADY = 1'b0;
            bus.M_PRDATA = 16'h0000;
            wait_cnt = 0;
        end
    end

    always @(posedge clk) begin
        if (reset && bus.M_PSELx && bus.M_PENABLE && bus.M_PREADY) begin
            apb_log.push_back({bus.M_PWRITE, bus.M_PADDR,
                               bus.M_PWRITE ? bus.M_PWDATA : bus.M_PRDATA});
            if (bus.M_PWRITE) slave_mem[bus.M_PADDR] = bus.M_PWDATA;
        end
    end

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'hA5A5);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge where C_ACK is seen, with C_REQ dropped.
    task automatic do_req(input logic we, input logic [15:0] a, input logic [15:0] d,
                          output int lat, output logic [15:0] rd, output logic err);
        bus.C_REQ = 1'b1;
        bus.C_WE = we;
        bus.C_ADDR = a;
        bus.C_WDATA = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.C_ACK !== 1'b1 && lat < 400);
        rd = bus.C_RDATA;
        err = bus.C_ERR;
        chk("ack_seen", bus.C_ACK, 1'b1);
        bus.C_REQ = 1'b0;
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d, output int lat);
        logic [15:0] rd;
        logic err;
        exp_log.push_back({1'b1, a, d});
        ref_mem[a] = d;
        do_req(1'b1, a, d, lat, rd, err);
    endtask

    task automatic load(input logic [15:0] a, output logic [15:0] rd, output logic err,
                        output int lat);
        exp_log.push_back({1'b0, a, model_rd(a)});
        do_req(1'b0, a, 16'h0000, lat, rd, err);
    endtask

    task automatic drain();
        int n = 0;
        while (apb_log.size() < exp_log.size() && n < 600) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("apb_count", apb_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < apb_log.size(); i++)
            chk("apb_xfer", apb_log[i], exp_log[i]);
        apb_log.delete();
        exp_log.delete();
    endtask

    initial begin
        int lat;
        int n;
        int hi;
        logic [15:0] rd;
        logic err;
        logic [15:0] a;
        logic [15:0] d;

        bus.C_REQ = 1'b0;
        bus.C_WE = 1'b0;
        bus.C_ADDR = '0;
        bus.C_WDATA = '0;
        repeat (3) @(negedge clk);

        chk("rst_ack", bus.C_ACK, 1'b0);
        chk("rst_err", bus.C_ERR, 1'b0);
        chk("rst_rdata", bus.C_RDATA, 16'h0);
        chk("rst_paddr", bus.M_PADDR, 16'h0);
        chk("rst_pwrite", bus.M_PWRITE, 1'b0);
        chk("rst_psel", bus.M_PSELx, 1'b0);
        chk("rst_penable", bus.M_PENABLE, 1'b0);
        chk("rst_pwdata", bus.M_PWDATA, 16'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single posted store, zero wait states.
        slave_wait = 0;
        store(16'h0011, 16'h1111, lat);
        chk("store_lat", lat, 1);
        n = 0;
        while (bus.M_PSELx !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("setup_psel", bus.M_PSELx, 1'b1);
        chk("setup_penable", bus.M_PENABLE, 1'b0);
        chk("setup_paddr", bus.M_PADDR, 16'h0011);
        chk("setup_pwrite", bus.M_PWRITE, 1'b1);
        chk("setup_pwdata", bus.M_PWDATA, 16'h1111);
        @(negedge clk);
        chk("access_penable", bus.M_PENABLE, 1'b1);
        chk("access_psel", bus.M_PSELx, 1'b1);
        chk("access_paddr", bus.M_PADDR, 16'h0011);
        drain();

        // Five back-to-back stores into a 4-deep buffer behind a slow slave.
        slave_wait = 10;
        for (int i = 0; i < 5; i++) begin
            store(16'h0020 + 16'(i), 16'($urandom), lat);
            if (i < 4) begin
                chk("wbuf_fast_ack", (lat <= 2), 1'b1);
            end else begin
                chk("wbuf_full_stall", (lat > 2), 1'b1);
                chk("wbuf_full_after_pop", (apb_log.size() >= 1), 1'b1);
            end
        end
        drain();

        // Store followed by a load of the same address must see the store.
        slave_wait = 1;
        store(16'h1003, 16'h3333, lat);
        load(16'h1003, rd, err, lat);
        chk("raw_rdata", rd, 16'h3333);
        chk("raw_order", apb_log.size(), exp_log.size());
        drain();

        // Minimum-latency load and C_RDATA hold.
        slave_wait = 0;
        slave_mem[16'h0040] = 16'hBEEF;
        ref_mem[16'h0040] = 16'hBEEF;
        repeat (2) @(negedge clk);
        load(16'h0040, rd, err, lat);
        chk("load_lat", lat, 3);
        chk("load_rdata", rd, 16'hBEEF);
        chk("load_err", err, 1'b0);
        repeat (5) @(negedge clk);
        chk("rdata_hold_idle", bus.C_RDATA, 16'hBEEF);
        store(16'h0041, 16'h1234, lat);
        chk("rdata_hold_store", bus.C_RDATA, 16'hBEEF);
        drain();
        chk("rdata_hold_drain", bus.C_RDATA, 16'hBEEF);

        // Random load/store mix against the program-order model.
        for (int k = 0; k < 40; k++) begin
            slave_wait = $urandom_range(0, 3);
            a = 16'h0100 + 16'($urandom_range(0, 7));
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                store(a, d, lat);
            end else begin
                load(a, rd, err, lat);
                chk("rnd_rdata", rd, model_rd(a));
                chk("rnd_err", err, 1'b0);
                chk("rnd_drained", apb_log.size(), exp_log.size());
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        // Reset during ACCESS of a posted store.
        slave_wait = 20;
        store(16'h0055, 16'hAAAA, lat);
        n = 0;
        while (!(bus.M_PSELx === 1'b1 && bus.M_PENABLE === 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_in_access", bus.M_PENABLE, 1'b1);
        reset = 1'b0;
        #1;
        chk("arst_psel", bus.M_PSELx, 1'b0);
        chk("arst_penable", bus.M_PENABLE, 1'b0);
        chk("arst_paddr", bus.M_PADDR, 16'h0);
        chk("arst_pwrite", bus.M_PWRITE, 1'b0);
        chk("arst_pwdata", bus.M_PWDATA, 16'h0);
        @(negedge clk);
        reset = 1'b1;
        exp_log.delete();
        ref_mem.delete(16'h0055);
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.M_PSELx === 1'b1) hi++;
        end
        chk("no_stale_psel", hi, 0);
        chk("no_stale_xfer", apb_log.size(), 0);
        slave_wait = 0;
        load(16'h0055, rd, err, lat);
        chk("no_stale_rdata", rd, 16'h0055 ^ 16'hA5A5);
        chk("post_rst_lat", lat, 3);
        drain();

`ifdef VMICRO16_APB_TIMEOUT_EN
        // Load to a slave that never becomes ready aborts after 8 ACCESS cycles.
        slave_wait = 1000;
        do_req(1'b0, 16'h0077, 16'h0000, lat, rd, err);
        chk("tmo_lat", lat, 10);
        chk("tmo_err", err, 1'b1);
        chk("tmo_rdata", rd, 16'hDEAD);
        chk("tmo_psel", bus.M_PSELx, 1'b0);
        @(negedge clk);
        chk("tmo_err_pulse", bus.C_ERR, 1'b0);
        slave_wait = 0;
        load(16'h0078, rd, err, lat);
        chk("tmo_next_rdata", rd, model_rd(16'h0078));
        chk("tmo_next_err", err, 1'b0);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
